// File: rtl/overworld_move_ctrl_if.sv
// Frame-sampled movement request in, camera offsets and sprite selection out.
interface overworld_move_ctrl_if;
  logic               VS;
  logic               Character_Moving;
  logic [1:0]         Direction;
  logic signed [12:0] topleftX;
  logic signed [12:0] topleftY;
  logic [1:0]         Facing;
  logic [3:0]         sprite_col;
  logic               walking;
  logic               step_done;
  logic               blocked;

  modport master (
    output VS, Character_Moving, Direction,
    input  topleftX, topleftY, Facing, sprite_col, walking, step_done, blocked
  );

  modport slave (
    input  VS, Character_Moving, Direction,
    output topleftX, topleftY, Facing, sprite_col, walking, step_done, blocked
  );
endinterface

// File: rtl/overworld_move_ctrl.sv
// Tile-locked overworld movement: one decision per VS frame, whole-tile steps,
// turn-in-place and refusal at camera bounds, plus walk-cycle sprite column.
module overworld_move_ctrl #(
  parameter int TILE_PX     = 16,
  parameter int TURN_FRAMES = 4,
  parameter int X_MIN       = -311,
  parameter int X_MAX       = 952,
  parameter int Y_MIN       = -340,
  parameter int Y_MAX       = 595,
  parameter int RESET_X     = 100,
  parameter int RESET_Y     = 100
) (
  input logic Clk,
  input logic Reset,
  overworld_move_ctrl_if.slave bus
);

  localparam int TC_W = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
  localparam logic [TC_W-1:0]   TC_LAST = TC_W'(TURN_FRAMES - 1);
  localparam logic [6:0]        M_LAST  = 7'(TILE_PX - 1);
  localparam logic [6:0]        M_HALF  = 7'(TILE_PX / 2);
  localparam logic signed [12:0] TILE_S = 13'(TILE_PX);
  localparam logic signed [12:0] XMIN_S = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S = 13'(X_MAX);
  localparam logic signed [12:0] YMIN_S = 13'(Y_MIN);
  localparam logic signed [12:0] YMAX_S = 13'(Y_MAX);

  typedef enum logic [1:0] {IDLE, TURN, WALK} state_t;

  function automatic logic signed [12:0] step_x(input logic [1:0] f, input logic signed [12:0] mag);
    case (f)
      2'd1:    step_x = mag;
      2'd3:    step_x = -mag;
      default: step_x = '0;
    endcase
  endfunction

  function automatic logic signed [12:0] step_y(input logic [1:0] f, input logic signed [12:0] mag);
    case (f)
      2'd0:    step_y = -mag;
      2'd2:    step_y = mag;
      default: step_y = '0;
    endcase
  endfunction

  function automatic logic in_bounds(input logic signed [12:0] tx, input logic signed [12:0] ty);
    in_bounds = (tx >= XMIN_S) && (tx <= XMAX_S) && (ty >= YMIN_S) && (ty <= YMAX_S);
  endfunction

  // Each facing owns three adjacent columns: foot0, rest, foot1.
  function automatic logic [3:0] col_of(input logic [1:0] f, input logic pose, input logic ft);
    logic [3:0] rest;
    case (f)
      2'd0:    rest = 4'd7;
      2'd1:    rest = 4'd10;
      2'd2:    rest = 4'd1;
      default: rest = 4'd4;
    endcase
    if (!pose)   col_of = rest;
    else if (ft) col_of = rest + 4'd1;
    else         col_of = rest - 4'd1;
  endfunction

  logic vs_s1, vs_s2, vs_prev, tick;
  state_t state, nxt_state;
  logic signed [12:0] x, y, nxt_x, nxt_y;
  logic signed [12:0] adv_x, adv_y, tgt_x, tgt_y, ntgt_x, ntgt_y;
  logic [1:0] facing, nxt_facing;
  logic [6:0] m, nxt_m;
  logic foot, nxt_foot;
  logic [TC_W-1:0] tcnt, nxt_tcnt;
  logic nxt_done, nxt_blk, walk_pose, same_req;
  logic [3:0] nxt_col;
  logic walking_r, done_r, blk_r;
  logic [3:0] col_r;

  assign tick     = vs_s2 & ~vs_prev;
  assign adv_x    = x + step_x(facing, 13'sd1);
  assign adv_y    = y + step_y(facing, 13'sd1);
  assign tgt_x    = x + step_x(facing, TILE_S);
  assign tgt_y    = y + step_y(facing, TILE_S);
  assign ntgt_x   = adv_x + step_x(facing, TILE_S);
  assign ntgt_y   = adv_y + step_y(facing, TILE_S);
  assign same_req = bus.Character_Moving && (bus.Direction == facing);

  always_comb begin
    nxt_state  = state;
    nxt_x      = x;
    nxt_y      = y;
    nxt_facing = facing;
    nxt_m      = m;
    nxt_foot   = foot;
    nxt_tcnt   = tcnt;
    nxt_done   = 1'b0;
    nxt_blk    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (bus.Character_Moving) begin
          if (bus.Direction != facing) begin
            nxt_facing = bus.Direction;
            nxt_tcnt   = '0;
            nxt_state  = TURN;
          end else if (in_bounds(tgt_x, tgt_y)) begin
            nxt_x     = adv_x;
            nxt_y     = adv_y;
            nxt_m     = 7'd1;
            nxt_state = WALK;
          end else begin
            nxt_blk = 1'b1;
          end
        end
        TURN: begin
          if (tcnt == TC_LAST) nxt_state = IDLE;
          else                 nxt_tcnt  = tcnt + 1'b1;
        end
        WALK: begin
          nxt_x = adv_x;
          nxt_y = adv_y;
          if (m == M_LAST) begin
            // Continuation is judged from the tile just reached, with this tick's inputs.
            nxt_done = 1'b1;
            nxt_m    = '0;
            nxt_foot = ~foot;
            if (!(same_req && in_bounds(ntgt_x, ntgt_y))) begin
              nxt_state = IDLE;
              nxt_blk   = same_req;
            end
          end else begin
            nxt_m = m + 7'd1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
    walk_pose = (nxt_state == WALK) && (nxt_m != '0) && (nxt_m <= M_HALF);
    nxt_col   = col_of(nxt_facing, walk_pose, nxt_foot);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_s1     <= 1'b1;
      vs_s2     <= 1'b1;
      vs_prev   <= 1'b1;
      state     <= IDLE;
      x         <= 13'(RESET_X);
      y         <= 13'(RESET_Y);
      facing    <= 2'd2;
      m         <= '0;
      foot      <= 1'b0;
      tcnt      <= '0;
      walking_r <= 1'b0;
      done_r    <= 1'b0;
      blk_r     <= 1'b0;
      col_r     <= 4'd1;
    end else begin
      vs_s1     <= bus.VS;
      vs_s2     <= vs_s1;
      vs_prev   <= vs_s2;
      state     <= nxt_state;
      x         <= nxt_x;
      y         <= nxt_y;
      facing    <= nxt_facing;
      m         <= nxt_m;
      foot      <= nxt_foot;
      tcnt      <= nxt_tcnt;
      walking_r <= (nxt_state == WALK);
      done_r    <= nxt_done;
      blk_r     <= nxt_blk;
      col_r     <= nxt_col;
    end
  end

  assign bus.topleftX   = x;
  assign bus.topleftY   = y;
  assign bus.Facing     = facing;
  assign bus.sprite_col = col_r;
  assign bus.walking    = walking_r;
  assign bus.step_done  = done_r;
  assign bus.blocked    = blk_r;

endmodule

// File: tb/tb_overworld_move_ctrl.sv
// Bench: three instances differing only in reset X, driven with common frames
// and compared against a tile-step model, vector tables and corner sequences.
module tb_overworld_move_ctrl;
  localparam int TILE = 16;
  localparam int TF   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b1;
  logic mv_in = 1'b0;
  logic [1:0] dir_in = 2'd0;

  always #5 clk = ~clk;

  overworld_move_ctrl_if ifa ();
  overworld_move_ctrl_if ifb ();
  overworld_move_ctrl_if ifc ();

  assign ifa.VS = vs; assign ifa.Character_Moving = mv_in; assign ifa.Direction = dir_in;
  assign ifb.VS = vs; assign ifb.Character_Moving = mv_in; assign ifb.Direction = dir_in;
  assign ifc.VS = vs; assign ifc.Character_Moving = mv_in; assign ifc.Direction = dir_in;

  overworld_move_ctrl #(.RESET_X(100))  dut_a (.Clk(clk), .Reset(rst), .bus(ifa.slave));
  overworld_move_ctrl #(.RESET_X(-300)) dut_b (.Clk(clk), .Reset(rst), .bus(ifb.slave));
  overworld_move_ctrl #(.RESET_X(-295)) dut_c (.Clk(clk), .Reset(rst), .bus(ifc.slave));

  logic signed [12:0] ox[3], oy[3];
  logic [1:0] ofc[3];
  logic [3:0] ocol[3];
  logic owalk[3], odone[3], oblk[3];
  assign ox[0] = ifa.topleftX; assign oy[0] = ifa.topleftY; assign ofc[0] = ifa.Facing;
  assign ocol[0] = ifa.sprite_col; assign owalk[0] = ifa.walking;
  assign odone[0] = ifa.step_done; assign oblk[0] = ifa.blocked;
  assign ox[1] = ifb.topleftX; assign oy[1] = ifb.topleftY; assign ofc[1] = ifb.Facing;
  assign ocol[1] = ifb.sprite_col; assign owalk[1] = ifb.walking;
  assign odone[1] = ifb.step_done; assign oblk[1] = ifb.blocked;
  assign ox[2] = ifc.topleftX; assign oy[2] = ifc.topleftY; assign ofc[2] = ifc.Facing;
  assign ocol[2] = ifc.sprite_col; assign owalk[2] = ifc.walking;
  assign odone[2] = ifc.step_done; assign oblk[2] = ifc.blocked;

  typedef struct {
    int x, y, facing, m, turn_left;
    bit walking, foot, done, blk;
  } mdl_t;

  typedef struct {
    int rst, mv, dir, x, y, facing, col, walk, done;
  } vec_t;

  mdl_t mdl[3];
  int rx[3] = '{100, -300, -295};
  int checks = 0;
  int failures = 0;
  int last_done[3], last_blk[3];
  vec_t vecs[23];

  function automatic bit legal(int tx, int ty);
    return tx >= -311 && tx <= 952 && ty >= -340 && ty <= 595;
  endfunction

  function automatic mdl_t mreset(int rxv);
    mdl_t s;
    s.x = rxv; s.y = 100; s.facing = 2; s.m = 0; s.turn_left = 0;
    s.walking = 0; s.foot = 0; s.done = 0; s.blk = 0;
    return s;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit mv, int dir);
    int ux, uy;
    s.done = 0; s.blk = 0;
    ux = (s.facing == 1) ? 1 : (s.facing == 3) ? -1 : 0;
    uy = (s.facing == 2) ? 1 : (s.facing == 0) ? -1 : 0;
    if (s.turn_left > 0) begin
      s.turn_left--;
    end else if (s.walking) begin
      s.x += ux; s.y += uy; s.m++;
      if (s.m == TILE) begin
        s.done = 1; s.m = 0; s.foot = !s.foot;
        if (!(mv && dir == s.facing && legal(s.x + TILE*ux, s.y + TILE*uy))) begin
          s.walking = 0;
          s.blk = mv && dir == s.facing;
        end
      end
    end else if (mv) begin
      if (dir != s.facing) begin
        s.facing = dir; s.turn_left = TF;
      end else if (legal(s.x + TILE*ux, s.y + TILE*uy)) begin
        s.x += ux; s.y += uy; s.m = 1; s.walking = 1;
      end else begin
        s.blk = 1;
      end
    end
    return s;
  endfunction

  function automatic int mcol(mdl_t s);
    int rest;
    rest = (s.facing == 0) ? 7 : (s.facing == 1) ? 10 : (s.facing == 2) ? 1 : 4;
    if (s.walking && s.m >= 1 && s.m <= TILE/2) return s.foot ? rest + 1 : rest - 1;
    return rest;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(ox[i]), mdl[i].x);
      chk($sformatf("%s_y%0d", tag, i), int'(oy[i]), mdl[i].y);
      chk($sformatf("%s_facing%0d", tag, i), int'(ofc[i]), mdl[i].facing);
      chk($sformatf("%s_col%0d", tag, i), int'(ocol[i]), mcol(mdl[i]));
      chk($sformatf("%s_walking%0d", tag, i), int'(owalk[i]), int'(mdl[i].walking));
      chk($sformatf("%s_done%0d", tag, i), int'(odone[i]), int'(mdl[i].done));
      chk($sformatf("%s_blocked%0d", tag, i), int'(oblk[i]), int'(mdl[i].blk));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = mreset(rx[i]);
    check_all("reset");
  endtask

  // One VS frame: low gap, rise, outputs checked on the tick edge and the edge after.
  task automatic frame(input bit mv, input logic [1:0] dir);
    @(negedge clk);
    vs = 1'b0; mv_in = mv; dir_in = dir;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mdl[i] = mstep(mdl[i], mv, int'(dir));
    check_all("tick");
    for (int i = 0; i < 3; i++) begin
      last_done[i] = int'(odone[i]);
      last_blk[i]  = int'(oblk[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin mdl[i].done = 0; mdl[i].blk = 0; end
    check_all("post");
  endtask

  initial begin
    int n;
    bit rmv;
    logic [1:0] rdir;

    n = 0;
    for (int k = 1; k <= 17; k++) begin
      vecs[n] = '{rst: (k == 1), mv: 1, dir: 2, x: 100, y: 100 + k, facing: 2,
                  col: (k <= 8) ? 0 : ((k <= 16) ? 1 : 2), walk: 1, done: (k == 16)};
      n++;
    end
    for (int k = 1; k <= 6; k++) begin
      vecs[n] = '{rst: (k == 1), mv: 1, dir: 3, x: (k == 6) ? 99 : 100, y: 100, facing: 3,
                  col: (k == 6) ? 3 : 4, walk: (k == 6), done: 0};
      n++;
    end

    // Reset with VS high, released with VS still high: no tick, no motion.
    do_reset();
    mv_in = 1'b1; dir_in = 2'd2;
    repeat (12) @(negedge clk);
    check_all("vs_high");

    for (int v = 0; v < 23; v++) begin
      if (vecs[v].rst != 0) do_reset();
      frame(vecs[v].mv != 0, 2'(vecs[v].dir));
      chk($sformatf("vec%0d_x", v), int'(ox[0]), vecs[v].x);
      chk($sformatf("vec%0d_y", v), int'(oy[0]), vecs[v].y);
      chk($sformatf("vec%0d_facing", v), int'(ofc[0]), vecs[v].facing);
      chk($sformatf("vec%0d_col", v), int'(ocol[0]), vecs[v].col);
      chk($sformatf("vec%0d_walking", v), int'(owalk[0]), vecs[v].walk);
      chk($sformatf("vec%0d_done", v), last_done[0], vecs[v].done);
    end

    // Moving released mid-step: step still completes, then stays put.
    do_reset();
    for (int k = 1; k <= 5; k++) frame(1'b1, 2'd2);
    for (int k = 6; k <= 16; k++) frame(1'b0, 2'd2);
    chk("drop_y", int'(oy[0]), 116);
    chk("drop_done", last_done[0], 1);
    chk("drop_walking", int'(owalk[0]), 0);
    chk("drop_col", int'(ocol[0]), 1);
    for (int k = 0; k < 3; k++) frame(1'b0, 2'd2);
    chk("drop_hold_y", int'(oy[0]), 116);

    // Left bound: -300 refused outright, -295 reaches -311 exactly then refuses.
    do_reset();
    for (int k = 1; k <= 6; k++) frame(1'b1, 2'd3);
    chk("bound_b_blocked", last_blk[1], 1);
    chk("bound_b_x", int'(ox[1]), -300);
    for (int k = 7; k <= 21; k++) frame(1'b1, 2'd3);
    chk("bound_c_x", int'(ox[2]), -311);
    chk("bound_c_done", last_done[2], 1);
    chk("bound_c_blocked", last_blk[2], 1);
    frame(1'b1, 2'd3);
    chk("bound_c_hold_x", int'(ox[2]), -311);

    // Reset mid-step aborts the step.
    do_reset();
    for (int k = 1; k <= 7; k++) frame(1'b1, 2'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mdl[i] = mreset(rx[i]);
    check_all("midrst");
    chk("midrst_y", int'(oy[0]), 100);
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0, 2'd2);
    chk("midrst_idle_y", int'(oy[0]), 100);

    // Random frames, direction biased toward repeating to get long walks.
    do_reset();
    rdir = 2'd2;
    for (int k = 0; k < 150; k++) begin
      rmv = ($urandom_range(9, 0) < 7);
      if ($urandom_range(9, 0) < 3) rdir = 2'($urandom_range(3, 0));
      frame(rmv, rdir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
